mem_bus_arbiter: RTL

//  Two-master arbiter for the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).

---
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus, with a
// watchdog that completes unanswered accesses with an error word.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   input  logic        timeout_clr,
   output logic        timeout_flag,
   output logic [31:0] timeout_addr,
   output logic [7:0]  timeout_cnt
);

   localparam int unsigned DW   = 32;
   localparam int unsigned WD_W = 16;
   localparam int unsigned TC_W = 8;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TC_W-1:0] TC_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t            state, state_d;
   logic              grant, grant_d;
   logic              last_grant, last_grant_d;
   logic [WD_W-1:0]   wd_cnt, wd_cnt_d;
   logic              done;
   logic              err;
   logic              g_valid;
   logic [DW-1:0]     done_rdata;

   // Granted master's request path
   assign g_valid = grant ? m1_valid : m0_valid;
   assign s_addr  = grant ? m1_addr  : m0_addr;
   assign s_wdata = grant ? m1_wdata : m0_wdata;
   assign s_wstrb = grant ? m1_wstrb : m0_wstrb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         wd_cnt     <= '0;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         last_grant <= last_grant_d;
         wd_cnt     <= wd_cnt_d;
      end
   end

   // Arbitration, completion and watchdog decisions
   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      wd_cnt_d     = wd_cnt;
      done         = 1'b0;
      err          = 1'b0;
      s_valid      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (m0_valid || m1_valid) begin
               state_d  = ST_BUSY;
               wd_cnt_d = '0;
               grant_d  = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
            end
         end
         ST_BUSY: begin
            if (!g_valid) begin
               // Requester abandoned the access: release quietly
               state_d      = ST_RELEASE;
               last_grant_d = grant;
            end else if (s_ready) begin
               s_valid      = 1'b1;
               done         = 1'b1;
               state_d      = ST_RELEASE;
               last_grant_d = grant;
            end else if (wd_cnt == WD_LAST) begin
               done         = 1'b1;
               err          = 1'b1;
               state_d      = ST_RELEASE;
               last_grant_d = grant;
            end else begin
               s_valid  = 1'b1;
               wd_cnt_d = wd_cnt + WD_W'(1);
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign done_rdata = err ? ERR_RDATA : s_rdata;
   assign m0_ready   = done && !grant;
   assign m1_ready   = done && grant;
   assign m0_rdata   = m0_ready ? done_rdata : '0;
   assign m1_rdata   = m1_ready ? done_rdata : '0;

   // Timeout status; a new timeout beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_flag <= 1'b0;
         timeout_addr <= '0;
         timeout_cnt  <= '0;
      end else if (err) begin
         timeout_flag <= 1'b1;
         timeout_addr <= s_addr;
         if (timeout_cnt != TC_MAX) timeout_cnt <= timeout_cnt + TC_W'(1);
      end else if (timeout_clr) begin
         timeout_flag <= 1'b0;
      end
   end

endmodule
